// File: rtl/pcie_wr_arb_if.sv
// Bundle of the two requester ports (A: PCIe RX writes, B: internal writer), the merged write port and stats.
interface pcie_wr_arb_if #(
   parameter int unsigned ADDR_W = 12
);
   logic [1:0]        a_if_select;
   logic [3:0]        a_mem_select;
   logic [ADDR_W-1:0] a_addr_hi;
   logic [ADDR_W-1:0] a_addr_lo;
   logic [31:0]       a_data_hi;
   logic [31:0]       a_data_lo;
   logic [3:0]        a_mask_hi;
   logic [3:0]        a_mask_lo;
   logic              a_en_hi;
   logic              a_en_lo;

   logic [1:0]        b_if_select;
   logic [3:0]        b_mem_select;
   logic [ADDR_W-1:0] b_addr_hi;
   logic [ADDR_W-1:0] b_addr_lo;
   logic [31:0]       b_data_hi;
   logic [31:0]       b_data_lo;
   logic [3:0]        b_mask_hi;
   logic [3:0]        b_mask_lo;
   logic              b_en_hi;
   logic              b_en_lo;
   logic              b_valid;
   logic              b_ready;

   logic [1:0]        wr_if_select;
   logic [3:0]        wr_mem_select;
   logic [ADDR_W-1:0] wr_addr_hi;
   logic [ADDR_W-1:0] wr_addr_lo;
   logic [31:0]       wr_data_hi;
   logic [31:0]       wr_data_lo;
   logic [3:0]        wr_mask_hi;
   logic [3:0]        wr_mask_lo;
   logic              wr_en_hi;
   logic              wr_en_lo;

   logic              stat_a_overflow;
   logic              stat_b_forced;

   // Arbiter side
   modport slave (
      input  a_if_select, a_mem_select, a_addr_hi, a_addr_lo, a_data_hi, a_data_lo,
             a_mask_hi, a_mask_lo, a_en_hi, a_en_lo,
      input  b_if_select, b_mem_select, b_addr_hi, b_addr_lo, b_data_hi, b_data_lo,
             b_mask_hi, b_mask_lo, b_en_hi, b_en_lo, b_valid,
      output b_ready,
      output wr_if_select, wr_mem_select, wr_addr_hi, wr_addr_lo, wr_data_hi, wr_data_lo,
             wr_mask_hi, wr_mask_lo, wr_en_hi, wr_en_lo,
      output stat_a_overflow, stat_b_forced
   );

   // Requester / observer side
   modport master (
      output a_if_select, a_mem_select, a_addr_hi, a_addr_lo, a_data_hi, a_data_lo,
             a_mask_hi, a_mask_lo, a_en_hi, a_en_lo,
      output b_if_select, b_mem_select, b_addr_hi, b_addr_lo, b_data_hi, b_data_lo,
             b_mask_hi, b_mask_lo, b_en_hi, b_en_lo, b_valid,
      input  b_ready,
      input  wr_if_select, wr_mem_select, wr_addr_hi, wr_addr_lo, wr_data_hi, wr_data_lo,
             wr_mask_hi, wr_mask_lo, wr_en_hi, wr_en_lo,
      input  stat_a_overflow, stat_b_forced
   );
endinterface

// File: rtl/pcie_wr_arb.sv
// Write-port arbiter: A (non-stallable PCIe RX) through a skid FIFO, B (valid/ready) with starvation guard.
// Optional macro PCIE_WR_ARB_BYPASS_EN: A beats skip an empty FIFO straight into the output register.
module pcie_wr_arb #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic          pcie_clk,
   input logic          rst_n,
   pcie_wr_arb_if.slave bus
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned CNT_W = 8;
`ifdef PCIE_WR_ARB_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]        if_select;
      logic [3:0]        mem_select;
      logic [ADDR_W-1:0] addr_hi;
      logic [ADDR_W-1:0] addr_lo;
      logic [31:0]       data_hi;
      logic [31:0]       data_lo;
      logic [3:0]        mask_hi;
      logic [3:0]        mask_lo;
      logic              en_hi;
      logic              en_lo;
   } beat_t;

   beat_t             a_beat;
   beat_t             b_beat;
   beat_t             fifo_head;
   beat_t             grant_beat;
   beat_t             out_q;
   beat_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  occ;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic              a_valid;
   logic              a_avail;
   logic              full;
   logic              empty;
   logic              force_b;
   logic              grant_a;
   logic              grant_b;
   logic              use_bypass;
   logic              pop;
   logic              push;
   logic              overflow;
   logic              overflow_q;
   logic              forced_q;

   assign a_beat = '{bus.a_if_select, bus.a_mem_select, bus.a_addr_hi, bus.a_addr_lo,
                     bus.a_data_hi, bus.a_data_lo, bus.a_mask_hi, bus.a_mask_lo,
                     bus.a_en_hi, bus.a_en_lo};
   assign b_beat = '{bus.b_if_select, bus.b_mem_select, bus.b_addr_hi, bus.b_addr_lo,
                     bus.b_data_hi, bus.b_data_lo, bus.b_mask_hi, bus.b_mask_lo,
                     bus.b_en_hi, bus.b_en_lo};

   assign a_valid   = bus.a_en_hi | bus.a_en_lo;
   assign full      = (occ == OCC_W'(FIFO_DEPTH));
   assign empty     = (occ == '0);
   assign fifo_head = fifo_mem[rd_ptr];

   // Priority: full FIFO, starved B, buffered A (or bypassed A), idle-port B
   always_comb begin
      a_avail    = 1'b0;
      force_b    = 1'b0;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      use_bypass = 1'b0;
      pop        = 1'b0;
      push       = 1'b0;
      overflow   = 1'b0;
      starve_nxt = starve_cnt;
      grant_beat = fifo_head;

      a_avail    = !empty || (BYPASS && a_valid);
      force_b    = !full && bus.b_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
      grant_a    = full || (a_avail && !force_b);
      grant_b    = !grant_a && bus.b_valid;
      use_bypass = grant_a && empty;
      pop        = grant_a && !empty;
      push       = a_valid && !use_bypass && (!full || pop);
      overflow   = a_valid && full && !pop;

      if (grant_b) begin
         grant_beat = b_beat;
      end else if (use_bypass) begin
         grant_beat = a_beat;
      end

      if (!bus.b_valid || grant_b) begin
         starve_nxt = '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         starve_nxt = starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge pcie_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         starve_cnt <= '0;
         out_q      <= '0;
         overflow_q <= 1'b0;
         forced_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         occ        <= occ + OCC_W'(push) - OCC_W'(pop);
         starve_cnt <= starve_nxt;
         overflow_q <= overflow;
         forced_q   <= force_b;
         // Idle cycles only drop the enables; the rest of the port keeps its last value
         if (grant_a || grant_b) begin
            out_q <= grant_beat;
         end else begin
            out_q.en_hi <= 1'b0;
            out_q.en_lo <= 1'b0;
         end
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge pcie_clk) begin
      if (push) fifo_mem[wr_ptr] <= a_beat;
   end

   assign bus.b_ready         = grant_b;
   assign bus.wr_if_select    = out_q.if_select;
   assign bus.wr_mem_select   = out_q.mem_select;
   assign bus.wr_addr_hi      = out_q.addr_hi;
   assign bus.wr_addr_lo      = out_q.addr_lo;
   assign bus.wr_data_hi      = out_q.data_hi;
   assign bus.wr_data_lo      = out_q.data_lo;
   assign bus.wr_mask_hi      = out_q.mask_hi;
   assign bus.wr_mask_lo      = out_q.mask_lo;
   assign bus.wr_en_hi        = out_q.en_hi;
   assign bus.wr_en_lo        = out_q.en_lo;
   assign bus.stat_a_overflow = overflow_q;
   assign bus.stat_b_forced   = forced_q;
endmodule

// File: doc/pcie_wr_arb.md
# pcie_wr_arb

Shares the single dual-lane (hi/lo) memory write interface between two requesters. Requester A is the PCIe RX write path, which cannot be back-pressured. Requester B is an internal agent, such as descriptor or status writeback, with a valid/ready handshake. A beats pass through a small skid FIFO so that B can be served without losing A traffic. A starvation counter guarantees B forward progress. Sits between the PCIe RX write logic / internal writer and the memory-select decode of the register/BRAM banks.

## Interface
- ADDR_W, 12: memory word address width (matches `MEM_ADDR_BITS`)
- FIFO_DEPTH, 4: A skid FIFO entries, power of two, ≥2
- STARVE_LIMIT, 8: B wait cycles before B is force-granted, 1..255
- pcie_clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_if_select / b_if_select  in  2  interface select
- a_mem_select / b_mem_select  in  4  memory select
- a_addr_hi, a_addr_lo / b_addr_hi, b_addr_lo  in  ADDR_W  lane addresses
- a_data_hi, a_data_lo / b_data_hi, b_data_lo  in  32  lane data
- a_mask_hi, a_mask_lo / b_mask_hi, b_mask_lo  in  4  byte masks
- a_en_hi, a_en_lo / b_en_hi, b_en_lo  in  1  lane enables
- b_valid  in  1  B beat offered
- b_ready  out  1  B beat accepted this cycle (combinational)
- wr_if_select, wr_mem_select, wr_addr_hi/lo, wr_data_hi/lo, wr_mask_hi/lo, wr_en_hi/lo  out  same widths as inputs  registered merged write port
- stat_a_overflow  out  1  one-cycle pulse: A beat dropped
- stat_b_forced  out  1  one-cycle pulse: B granted by starvation rule

## Operation
- A beat: any cycle with a_en_hi|a_en_lo. The full beat (all a_* fields) is pushed into the FIFO at the clock edge.
- B beat: transferred when b_valid & b_ready. B must hold all b_* fields stable while b_valid & !b_ready.
- Arbitration each cycle, in order:
  - If the FIFO is full, grant A.
  - Else if b_valid & starve_cnt==STARVE_LIMIT, grant B and pulse stat_b_forced.
  - Else if the FIFO is non-empty, grant A (pop the head).
  - Else if b_valid, grant B.
  - Else no grant.
- b_ready = B granted.
- starve_cnt (8 bit):
  - Increments, saturating at STARVE_LIMIT, on b_valid & !b_ready.
  - Clears to 0 on a B transfer or when b_valid is low.
- Overflow: an A beat arrives while the FIFO is full and no pop occurs that cycle. The beat is dropped, stat_a_overflow pulses, and FIFO contents are unchanged.
- Push and pop in the same cycle are legal at any occupancy, including full. Occupancy is then unchanged.
- Output register:
  - On a grant, loads the granted beat's fields.
  - With no grant, wr_en_hi/lo load 0 and all other wr_* hold their previous values.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The occupancy counter is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release): all wr_* outputs, stat_* and FIFO occupancy go to 0; starve_cnt goes to 0. Asserting reset mid-stream discards all buffered A beats.
- A latency:
  - The beat is presented in cycle k and enters the FIFO at edge k.
  - It appears on wr_* after edge k+1 when granted (2 cycles), or later if B holds the port.
- B latency: beat accepted in cycle k appears on wr_* after edge k (1 cycle).
- Throughput: one beat per cycle on the output. Back-to-back A bursts sustain full rate with FIFO occupancy ≤1.
- stat_* pulses are registered and assert in the cycle after the event.

## Configuration
- PCIE_WR_ARB_BYPASS_EN:
  - Defined: an A beat arriving with the FIFO empty, when the arbiter would grant A, skips the FIFO and is loaded directly into the output register at edge k (A latency 1). When the bypass is used the FIFO is not pushed. A grant to B that cycle pushes the beat normally.
  - Undefined: every A beat goes through the FIFO (latency 2).

## Test plan
- Single A beat (addr_hi 0x010, data 0xDEADBEEF, mask 0xF, en_hi only) with B idle -> wr_en_hi=1 with those values 2 cycles later (1 cycle with PCIE_WR_ARB_BYPASS_EN); wr_en_lo=0.
- B beat with A idle, b_valid held 1 -> b_ready=1 same cycle; wr_* show B fields next cycle; b_ready drops when b_valid drops.
- Continuous A beats for 20 cycles, B valid from cycle 0, STARVE_LIMIT=8 -> B granted in cycle 8, stat_b_forced pulses; that cycle's A beat is buffered; no A beat is lost and A order is preserved.
- FIFO_DEPTH=4, A every cycle, B forced repeatedly until full -> A granted while full; a push into a full FIFO with no pop pulses stat_a_overflow exactly once per dropped beat.
- Simultaneous push/pop at full occupancy -> occupancy stays 4, no overflow pulse.
- rst_n asserted with 3 beats buffered -> wr_en_* 0 immediately; after release, no stale beat is emitted.
